periph_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the single-ported peripheral bus (LED block, GPIO and similar `read`/`write`/`response` slaves).
- Master 0 is the CPU load/store unit; master 1 is the debug/UART bridge.
- Shares the slave between the two masters using registered round-robin grants.
- Returns each response to the master that owns the transaction; times out hung slaves with an error flag.

---
 rtl/periph_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for a single-ported peripheral slave.
// Grants are registered; responses are steered back combinationally, and a hung slave is aborted after TIMEOUT cycles.
module periph_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  output logic [31:0] m0_read_data,
  output logic        m0_response,
  output logic        m0_error,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_response,
  output logic        m1_error,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  input  logic [31:0] s_read_data,
  input  logic        s_response
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       m0_req_s, m1_req_s;
  logic       expire_s;

  assign m0_req_s = m0_read | m0_write;
  assign m1_req_s = m1_read | m1_write;

  // Expiry depends only on registered state, so gating the strobes with it
  // cannot loop back through a combinational slave response.
  assign expire_s = ((state_q == BUSY_M0) || (state_q == BUSY_M1)) && (cnt_q == CNT_LAST);

  // State, round-robin history and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/timeout in BUSY.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (m0_req_s && m1_req_s) begin
          state_d = last_q ? BUSY_M0 : BUSY_M1;
        end else if (m0_req_s) begin
          state_d = BUSY_M0;
        end else if (m1_req_s) begin
          state_d = BUSY_M1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_M0: begin
        if (s_response || expire_s) begin
          state_d = IDLE;
          last_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUSY_M1: begin
        if (s_response || expire_s) begin
          state_d = IDLE;
          last_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs: forward the owning master to the slave and route its response back.
  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = 32'd0;
    s_write_data = 32'd0;
    m0_response  = 1'b0;
    m0_error     = 1'b0;
    m0_read_data = 32'd0;
    m1_response  = 1'b0;
    m1_error     = 1'b0;
    m1_read_data = 32'd0;
    case (state_q)
      BUSY_M0: begin
        s_read       = m0_read & ~expire_s;
        s_write      = m0_write & ~expire_s;
        s_address    = m0_address;
        s_write_data = m0_write_data;
        if (s_response) begin
          m0_response  = 1'b1;
          m0_read_data = s_read_data;
        end else if (expire_s) begin
          m0_response  = 1'b1;
          m0_error     = 1'b1;
          m0_read_data = m0_read ? ERR_DATA : 32'd0;
        end else begin
          m0_response  = 1'b0;
        end
      end
      BUSY_M1: begin
        s_read       = m1_read & ~expire_s;
        s_write      = m1_write & ~expire_s;
        s_address    = m1_address;
        s_write_data = m1_write_data;
        if (s_response) begin
          m1_response  = 1'b1;
          m1_read_data = s_read_data;
        end else if (expire_s) begin
          m1_response  = 1'b1;
          m1_error     = 1'b1;
          m1_read_data = m1_read ? ERR_DATA : 32'd0;
        end else begin
          m1_response  = 1'b0;
        end
      end
      default: begin
        s_read = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter with an LED-style slave whose latency is selectable.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_response, m0_error, m1_response, m1_error;
  logic        s_read, s_write, s_response;
  logic [31:0] s_address, s_write_data, s_read_data;

  int errors = 0;
  int checks = 0;

  // Slave model: mode 0 combinational, 1 never answers, 2 answers on the 3rd strobe cycle.
  logic [1:0]  mode = 2'd0;
  logic [1:0]  lat_q = 2'd0;
  logic [31:0] led_q = 32'd0;

  assign s_response  = (s_read | s_write) && ((mode == 2'd0) || ((mode == 2'd2) && (lat_q == 2'd2)));
  assign s_read_data = led_q;

  always @(posedge clk) begin
    if (s_write && s_response) led_q <= s_write_data;
    if ((s_read | s_write) && !s_response) lat_q <= lat_q + 2'd1;
    else lat_q <= 2'd0;
  end

  always #5 clk = ~clk;

  periph_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
    .m0_response(m0_response), .m0_error(m0_error),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
    .m1_response(m1_response), .m1_error(m1_error),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_write_data(s_write_data), .s_read_data(s_read_data),
    .s_response(s_response)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, ".s_read"}, s_read, 1'b0);
    chk1({tag, ".s_write"}, s_write, 1'b0);
    chk32({tag, ".s_address"}, s_address, 32'd0);
    chk32({tag, ".s_write_data"}, s_write_data, 32'd0);
    chk1({tag, ".m0_response"}, m0_response, 1'b0);
    chk1({tag, ".m0_error"}, m0_error, 1'b0);
    chk32({tag, ".m0_read_data"}, m0_read_data, 32'd0);
    chk1({tag, ".m1_response"}, m1_response, 1'b0);
    chk1({tag, ".m1_error"}, m1_error, 1'b0);
    chk32({tag, ".m1_read_data"}, m1_read_data, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 32'd0; m0_write_data = 32'd0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 32'd0; m1_write_data = 32'd0;
    #12;
    chk_quiet("reset");
    reset = 1'b1;

    // 1: master 0 write through to the LED register
    m0_write = 1'b1; m0_write_data = 32'h000000A5;
    tick();
    chk1("t1.s_write", s_write, 1'b1);
    chk32("t1.s_write_data", s_write_data, 32'h000000A5);
    chk1("t1.m0_response", m0_response, 1'b1);
    chk1("t1.m0_error", m0_error, 1'b0);
    chk1("t1.m1_response", m1_response, 1'b0);
    tick();
    chk32("t1.led", led_q, 32'h000000A5);
    chk1("t1.idle_s_write", s_write, 1'b0);
    chk1("t1.idle_m0_response", m0_response, 1'b0);
    m0_write = 1'b0;

    // 2: simultaneous reads right after reset, master 0 wins the tie
    reset = 1'b0; #2; reset = 1'b1;
    m0_read = 1'b1; m1_read = 1'b1;
    tick();
    chk1("t2.m0_response", m0_response, 1'b1);
    chk32("t2.m0_read_data", m0_read_data, 32'h000000A5);
    chk1("t2.m1_response_c2", m1_response, 1'b0);
    chk32("t2.m1_read_data_c2", m1_read_data, 32'd0);
    tick();
    chk1("t2.gap_m0", m0_response, 1'b0);
    chk1("t2.gap_m1", m1_response, 1'b0);
    chk1("t2.gap_s_read", s_read, 1'b0);
    m0_read = 1'b0;
    tick();
    chk1("t2.m1_response", m1_response, 1'b1);
    chk32("t2.m1_read_data", m1_read_data, 32'h000000A5);
    chk1("t2.m0_response_c4", m0_response, 1'b0);
    tick();
    chk1("t2.done_m1", m1_response, 1'b0);
    m1_read = 1'b0;

    // 3: continuous requests from both, grants must alternate 0,1,0,1,0,1
    m0_read = 1'b1; m1_read = 1'b1;
    for (int c = 2; c <= 13; c++) begin
      tick();
      chk1($sformatf("t3.m0_response_c%0d", c), m0_response, (c % 4) == 2);
      chk1($sformatf("t3.m1_response_c%0d", c), m1_response, (c % 4) == 0);
    end
    m0_read = 1'b0; m1_read = 1'b0;

    // 4: hung slave, read from master 1 times out on the 16th busy cycle
    mode = 2'd1;
    m1_read = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk1($sformatf("t4.wait_resp_c%0d", c), m1_response, 1'b0);
      chk1($sformatf("t4.wait_s_read_c%0d", c), s_read, 1'b1);
    end
    tick();
    chk1("t4.m1_response", m1_response, 1'b1);
    chk1("t4.m1_error", m1_error, 1'b1);
    chk32("t4.m1_read_data", m1_read_data, 32'hDEADBEEF);
    chk1("t4.s_read_forced", s_read, 1'b0);
    chk1("t4.m0_response", m0_response, 1'b0);
    tick();
    chk1("t4.idle_m1", m1_response, 1'b0);
    m1_read = 1'b0;
    mode = 2'd0;
    m0_write = 1'b1; m0_write_data = 32'h0000003C;
    tick();
    chk1("t4.m0_after_resp", m0_response, 1'b1);
    chk1("t4.m0_after_err", m0_error, 1'b0);
    tick();
    m0_write = 1'b0;
    chk32("t4.led", led_q, 32'h0000003C);

    // 4b: a timed-out write returns zero data with the error flag
    mode = 2'd1;
    m0_write = 1'b1; m0_write_data = 32'h00000055;
    repeat (15) tick();
    chk1("t4b.wait_resp", m0_response, 1'b0);
    tick();
    chk1("t4b.m0_response", m0_response, 1'b1);
    chk1("t4b.m0_error", m0_error, 1'b1);
    chk32("t4b.m0_read_data", m0_read_data, 32'd0);
    chk1("t4b.s_write_forced", s_write, 1'b0);
    tick();
    m0_write = 1'b0;
    mode = 2'd0;

    // 5a: async reset aborts a stalled m0 read; lone m1 is then granted
    mode = 2'd1;
    m0_read = 1'b1;
    tick();
    tick();
    chk1("t5a.busy_s_read", s_read, 1'b1);
    #2 reset = 1'b0;
    #1 chk_quiet("t5a.in_reset");
    m0_read = 1'b0; m1_read = 1'b1; mode = 2'd0;
    #1 reset = 1'b1;
    tick();
    chk1("t5a.m1_response", m1_response, 1'b1);
    chk1("t5a.m0_response", m0_response, 1'b0);
    tick();
    m1_read = 1'b0;

    // 5b: leave last=0, abort by reset, then a tie must go to master 0
    m0_read = 1'b1;
    tick();
    chk1("t5b.pre_m0_response", m0_response, 1'b1);
    tick();
    mode = 2'd1;
    tick();
    tick();
    #2 reset = 1'b0;
    #1 chk_quiet("t5b.in_reset");
    mode = 2'd0; m1_read = 1'b1;
    #1 reset = 1'b1;
    tick();
    chk1("t5b.m0_first", m0_response, 1'b1);
    chk1("t5b.m1_not_first", m1_response, 1'b0);
    tick();
    m0_read = 1'b0;
    tick();
    chk1("t5b.m1_second", m1_response, 1'b1);
    tick();
    m1_read = 1'b0;

    // 6: slave answers on its 3rd cycle; strobes and address stay steady
    mode = 2'd2;
    m0_write = 1'b1; m0_address = 32'h00000010; m0_write_data = 32'h00000077;
    tick();
    chk1("t6.c2_s_write", s_write, 1'b1);
    chk32("t6.c2_s_address", s_address, 32'h00000010);
    chk1("t6.c2_resp", m0_response, 1'b0);
    chk32("t6.c2_read_data", m0_read_data, 32'd0);
    tick();
    chk1("t6.c3_s_write", s_write, 1'b1);
    chk32("t6.c3_s_address", s_address, 32'h00000010);
    chk32("t6.c3_s_write_data", s_write_data, 32'h00000077);
    chk1("t6.c3_resp", m0_response, 1'b0);
    tick();
    chk1("t6.c4_s_write", s_write, 1'b1);
    chk32("t6.c4_s_address", s_address, 32'h00000010);
    chk1("t6.c4_resp", m0_response, 1'b1);
    chk1("t6.c4_error", m0_error, 1'b0);
    tick();
    m0_write = 1'b0;
    chk32("t6.led", led_q, 32'h00000077);
    chk1("t6.idle_resp", m0_response, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
